// File: rtl/ps2_keycode_source.sv
// PS/2 Set-2 receiver that turns keys "1".."7" into a held keycode
// and hands it to the synthesizer over a ready/request handshake.
module ps2_keycode_source #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  input  logic       data_request,
  output logic [3:0] keycode,
  output logic       data_ready,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, HELD, DONE} state_t;

  logic          c_s1_q, c_s2_q, d_s1_q, d_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;
  logic [3:0]    bcnt_q, bcnt_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          rxv_q, rxv_d;
  logic          ferr_q, ferr_d;
  logic [7:0]    rx_byte;
  logic          brk_q, brk_d, ext_q, ext_d;
  logic          ev;
  logic [3:0]    ev_key;
  logic          mk, bk;
  state_t        st_q, st_d;
  logic [7:0]    lat_q, lat_d;
  logic [3:0]    key_q, key_d;

  assign rx_byte = sh_q;

  // Glitch filter: flip the clean clock after FILTER_LEN differing samples
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (c_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1))
        filt_d = c_s2_q;
      else
        fcnt_d = fcnt_q + 1'b1;
    end
  end

  assign fall = filt_q & ~filt_d;

  // Frame receiver with inter-edge timeout
  always_comb begin
    bcnt_d = bcnt_q;
    sh_d   = sh_q;
    par_d  = par_q;
    tcnt_d = tcnt_q;
    rxv_d  = 1'b0;
    ferr_d = 1'b0;
    if (fall) begin
      tcnt_d = '0;
      unique case (1'b1)
        (bcnt_q == 4'd0): begin
          if (!d_s2_q) bcnt_d = 4'd1;
        end
        (bcnt_q >= 4'd1 && bcnt_q <= 4'd8): begin
          sh_d   = {d_s2_q, sh_q[7:1]};
          bcnt_d = bcnt_q + 4'd1;
        end
        (bcnt_q == 4'd9): begin
          par_d  = d_s2_q;
          bcnt_d = 4'd10;
        end
        default: begin
          bcnt_d = 4'd0;
          if ((^{sh_q, par_q}) && d_s2_q)
            rxv_d = 1'b1;
          else
            ferr_d = 1'b1;
        end
      endcase
    end else if (bcnt_q != 4'd0) begin
      if (tcnt_q == TW'(TIMEOUT - 1)) begin
        bcnt_d = 4'd0;
        tcnt_d = '0;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end
  end

  // Scancode prefix tracking and event qualification
  always_comb begin
    brk_d = brk_q;
    ext_d = ext_q;
    ev    = 1'b0;
    if (rxv_q) begin
      unique case (1'b1)
        (rx_byte == 8'hF0): brk_d = 1'b1;
        (rx_byte == 8'hE0): ext_d = 1'b1;
        default: begin
          brk_d = 1'b0;
          ext_d = 1'b0;
          ev    = ~ext_q;
        end
      endcase
    end
  end

  // Key "1".."7" to keycode map
  always_comb begin
    ev_key = 4'd0;
    case (rx_byte)
      8'h16:   ev_key = 4'd1;
      8'h1E:   ev_key = 4'd2;
      8'h26:   ev_key = 4'd3;
      8'h25:   ev_key = 4'd4;
      8'h2E:   ev_key = 4'd5;
      8'h36:   ev_key = 4'd6;
      8'h3D:   ev_key = 4'd7;
      default: ev_key = 4'd0;
    endcase
  end

  assign mk = ev && (ev_key != 4'd0) && !brk_q;
  assign bk = ev && (ev_key != 4'd0) && brk_q && (rx_byte == lat_q);

  // Monophonic handshake FSM
  always_comb begin
    st_d  = st_q;
    lat_d = lat_q;
    key_d = key_q;
    case (st_q)
      IDLE: begin
        if (mk && data_request) begin
          st_d  = HELD;
          lat_d = rx_byte;
          key_d = ev_key;
        end
      end
      HELD: begin
        if (bk)
          st_d = IDLE;
        else if (!data_request)
          st_d = DONE;
      end
      DONE: begin
        if (bk) begin
          st_d = IDLE;
        end else if (mk && rx_byte != lat_q && data_request) begin
          st_d  = HELD;
          lat_d = rx_byte;
          key_d = ev_key;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      c_s1_q <= 1'b1;
      c_s2_q <= 1'b1;
      d_s1_q <= 1'b1;
      d_s2_q <= 1'b1;
      filt_q <= 1'b1;
      fcnt_q <= '0;
      bcnt_q <= 4'd0;
      sh_q   <= 8'd0;
      par_q  <= 1'b0;
      tcnt_q <= '0;
      rxv_q  <= 1'b0;
      ferr_q <= 1'b0;
      brk_q  <= 1'b0;
      ext_q  <= 1'b0;
      st_q   <= IDLE;
      lat_q  <= 8'd0;
      key_q  <= 4'd0;
    end else begin
      c_s1_q <= PS2_CLK;
      c_s2_q <= c_s1_q;
      d_s1_q <= PS2_DAT;
      d_s2_q <= d_s1_q;
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
      bcnt_q <= bcnt_d;
      sh_q   <= sh_d;
      par_q  <= par_d;
      tcnt_q <= tcnt_d;
      rxv_q  <= rxv_d;
      ferr_q <= ferr_d;
      brk_q  <= brk_d;
      ext_q  <= ext_d;
      st_q   <= st_d;
      lat_q  <= lat_d;
      key_q  <= key_d;
    end
  end

  assign keycode    = key_q;
  assign data_ready = (st_q == HELD);
  assign frame_err  = ferr_q;

endmodule

// File: doc/ps2_keycode_source.md
# ps2_keycode_source

Producer side of the keycode/handshake interface consumed by the synthesizer: receives PS/2 Set-2 scancodes from the keyboard, maps keys "1".."7" to keycodes 1..7, and drives `keycode`/`data_ready` against the synthesizer's `data_request`. `data_ready` stays high while the key is physically held, so releasing the key cuts the note short. The keyboard link is device-to-host only; this block never drives PS/2 lines.

## Interface
- `FILTER_LEN`, default 8: number of consecutive equal synchronized `PS2_CLK` samples required to accept a new level.
- `TIMEOUT`, default 50000: idle cycles (1 ms at 50 MHz) between accepted falling edges after which a partial frame is discarded.
- `CLOCK_50`  in  1  system clock, 50 MHz. One clock domain.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `PS2_CLK`  in  1  keyboard clock, asynchronous.
- `PS2_DAT`  in  1  keyboard data, asynchronous.
- `data_request`  in  1  consumer ready / still playing (synthesizer `data_request`).
- `keycode`  out  4  1..7 for keys "1".."7"; 0 otherwise.
- `data_ready`  out  1  keycode valid, key held.
- `frame_err`  out  1  one-cycle pulse on a discarded frame.

## Operation
- **Input conditioning**
  - Two-flop synchronizer on `PS2_CLK` and `PS2_DAT`.
  - Filtered clock changes only after `FILTER_LEN` equal samples.
  - A filtered 1→0 transition samples the synchronized `PS2_DAT`.
- **Frame receiver**
  - Frame is 11 bits: start=0, 8 data bits LSB first, odd parity, stop=1.
  - Bit counter 0..10.
  - Start bit = 1: discard immediately and stay at count 0. No `frame_err`.
  - After bit 10:
    - Parity odd and stop = 1: one-cycle internal strobe `rx_valid` with `rx_byte`.
    - Otherwise: `frame_err` pulse, no strobe.
  - Timeout counter resets on each accepted falling edge. It counts only while the bit counter ≠ 0. Reaching `TIMEOUT` clears the bit counter, with no `frame_err`.
- **Scancode decode** (flags `brk`, `ext`; both cleared by reset)
  - 0xF0: set `brk`.
  - 0xE0: set `ext`.
  - Any other byte: event = (code, `brk`, `ext`), then clear both flags.
  - Events with `ext` = 1 are ignored.
  - Map: 0x16→1, 0x1E→2, 0x26→3, 0x25→4, 0x2E→5, 0x36→6, 0x3D→7.
  - Unmapped codes are ignored entirely (no handshake).
- **Handshake FSM** (registered `lat_code`, `keycode`)
  - IDLE, `data_ready` = 0.
    - Mapped make with `data_request` = 1: latch scancode and keycode, go to HELD.
    - Mapped make with `data_request` = 0: drop the event.
  - HELD, `data_ready` = 1, `keycode` stable.
    - Break of `lat_code`: go to IDLE.
    - Else `data_request` = 0 (consumer finished its duration): go to DONE.
    - Break has priority if both occur in the same cycle.
    - Repeated makes (typematic) and other keys' makes or breaks: ignored. Monophonic.
  - DONE, `data_ready` = 0.
    - Break of `lat_code`: go to IDLE.
    - Make of a different mapped key with `data_request` = 1: latch it, go to HELD.
    - Typematic repeats of `lat_code`: ignored (no retrigger).
  - `keycode` holds its last value in IDLE/DONE. It updates only on entry to HELD.

## Timing
- Reset values: `keycode` = 0, `data_ready` = 0, `frame_err` = 0, FSM = IDLE, bit counter = 0, flags cleared. Reset applies asynchronously mid-frame or mid-HELD.
- `rx_valid`/`frame_err` assert the cycle after the filtered falling edge of bit 10 is detected.
- `data_ready` and `keycode` change the cycle after `rx_valid` (1-cycle decode→FSM latency).
- Entry to DONE: `data_ready` falls the cycle after `data_request` is sampled low.
- `data_request` is sampled each cycle. It is synchronous to `CLOCK_50` and needs no synchronizer.
- `keycode` never changes while `data_ready` = 1.

## Test plan
- **Press and release:** `data_request` = 1, frame 0x16 → `keycode` = 1, `data_ready` = 1 two cycles after the stop-bit edge. Then frames F0,16 → `data_ready` = 0 one cycle after the 0x16 strobe.
- **Consumer finishes first, typematic ignored:** hold 0x26 (`keycode` = 3), drop `data_request` → `data_ready` = 0 next cycle. Repeated 0x26 frames → no reassert. F0,26 then 0x3D with `data_request` = 1 → `keycode` = 7, `data_ready` = 1.
- **Bad frames:** 0x1E with even parity → one `frame_err` pulse, `data_ready` stays 0. Stop bit = 0 → same. Then a valid 0x1E → `keycode` = 2.
- **Ignored codes:** E0,16 and 0x1C and F0,1C → `data_ready` stays 0, `keycode` unchanged. Next plain 0x2E → `keycode` = 5.
- **Timeout and glitch:** 5 bits, then `TIMEOUT`+10 idle cycles, then a full 0x25 frame → `keycode` = 4, no `frame_err`. A 3-cycle low glitch on `PS2_CLK` (< `FILTER_LEN`) → no bit sampled.
- **Reset mid-operation:** `reset_n` low during HELD → `data_ready` = 0 and `keycode` = 0 without a clock edge. After release, 0x36 → `keycode` = 6.
